mem_store: RTL and testbench
============================

// Module: mem_store
//
// PURPOSE
//  Write-side counterpart of the byte-serial instruction fetch path.
//  - Accepts one store request: address, word data, size.
//  - Serialises the sized value onto the byte-wide memory port, one byte per cycle.
//  - Byte order is big-endian: the most significant byte of the sized value goes to the lowest address.
//  - Sits between the execute/memory stage and the shared byte-wide RAM port.
//
// PARAMETERS
//  WORD_WIDTH  32  store data width in bits; multiple of 8; NB = WORD_WIDTH/8 bytes
//  ADDR_WIDTH  16  memory address width in bits
//  DATA_WIDTH   8  memory data port width; fixed at 8
//
// PORTS
//  i_clk        in   1           clock; all logic on rising edge
//  i_rst        in   1           reset; synchronous, active-high
//  i_req        in   1           store request strobe
//  i_addr       in   ADDR_WIDTH  byte address of first (MS) byte
//  i_data       in   WORD_WIDTH  store value, right-aligned (LSBs significant)
//  i_size       in   2           log2(bytes): 0=byte, 1=half, 2=word; 3 reserved
//  o_busy       out  1           store in progress; requests ignored
//  o_done       out  1           1-cycle pulse after last byte written
//  o_err        out  1           1-cycle pulse when request rejected (bad size)
//  o_mem_addr   out  ADDR_WIDTH  memory byte address (registered)
//  o_mem_data   out  DATA_WIDTH  memory write byte (registered)
//  o_mem_write  out  1           memory write enable (registered)
//
// BEHAVIOUR
//  Reset
//  - On reset: every output = 0; FSM = IDLE; byte counter = 0; latched request cleared.
//  - Reset mid-store: o_mem_write = 0 from the next edge; no further bytes written; no o_done.
//
//  Accept
//  - A request is accepted on an edge where i_req=1 in IDLE or DONE state (o_busy=0).
//  - On accept, latch i_addr, i_data and N = 2**i_size.
//  - i_req while o_busy=1 is ignored; it is not queued.
//
//  Reject
//  - A request is rejected when 2**i_size > NB; with the defaults this is i_size=3.
//  - On reject: o_err=1 for one cycle; no memory write; FSM stays in IDLE.
//
//  FSM
//  - IDLE -> WRITE on an accepted request.
//  - WRITE -> WRITE while k < N-1; k increments each cycle.
//  - WRITE -> DONE at k = N-1.
//  - DONE -> WRITE on a new accepted request; otherwise DONE -> IDLE.
//
//  Write sequence
//  - In WRITE at byte k (0..N-1): o_mem_write=1, o_mem_addr = addr+k, o_mem_data = data[(N-k)*8-1 -: 8].
//  - Address add wraps modulo 2**ADDR_WIDTH.
//  - No alignment check: a misaligned address is legal.
//
//  Timing
//  - The first write cycle is the cycle after accept. Byte k is visible in cycle accept+1+k.
//  - o_busy=1 exactly during the WRITE cycles.
//  - o_done=1 in cycle accept+N+1. A new request may be accepted in that same cycle, so back-to-back stores leave one idle bus cycle.
//
//  Outside WRITE
//  - o_mem_write=0.
//  - o_mem_addr and o_mem_data hold their last values.
//
//  Simultaneous events
//  - i_rst has priority over i_req.
//  - A reject while in DONE still completes the DONE pulse, then goes to IDLE.
//
// TESTING
//  1. Word: req addr=0x0100, data=0xDEADBEEF, size=2 -> writes 0x0100=DE, 0x0101=AD, 0x0102=BE, 0x0103=EF in cycles +1..+4; o_done at +5.
//  2. Byte/half: size=0, data=0x12345678 -> one write of 78; size=1 at 0x0200 -> 0x0200=56, 0x0201=78.
//  3. Wrap: size=2, addr=0xFFFE, data=0x11223344 -> 0xFFFE=11, 0xFFFF=22, 0x0000=33, 0x0001=44.
//  4. Busy: second req with data 0xCAFEBABE during a word store -> ignored; only the first store's 4 bytes appear; issuing it on the o_done cycle starts it the next cycle.
//  5. Reject: size=3 -> o_err pulse; o_mem_write stays 0; o_busy stays 0.
//  6. Reset: assert i_rst after 2 bytes of a word store -> o_mem_write=0 next cycle; no o_done; next req behaves as in test 1.

Source files
------------

// File: rtl/mem_store.sv
// mem_store: byte-serial store engine.
// Takes one sized store request and writes it to a byte-wide RAM port,
// most significant byte first at the lowest address, one byte per cycle.
// Every memory-side output is registered.
module mem_store #(
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [WORD_WIDTH-1:0] i_data,
  input  logic [1:0]            i_size,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_data,
  output logic                  o_mem_write
);

  localparam int NB = WORD_WIDTH / 8;
  localparam int CW = $clog2(NB) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e                r_state;
  state_e                w_next;

  // Latched request. r_shift holds the not-yet-written bytes, left-aligned,
  // so the next byte to emit is always the top byte of the register.
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WORD_WIDTH-1:0] r_shift;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         r_last;

  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_data;
  logic                  r_mem_write;

  logic                  w_open;
  logic [31:0]           w_req_n;
  logic                  w_size_ok;
  logic                  w_accept;
  logic                  w_reject;
  logic [31:0]           w_shamt;
  logic [WORD_WIDTH-1:0] w_aligned;
  logic                  w_last_byte;

  // Request qualification: a request is seen only while no store is in flight.
  always_comb begin
    w_open      = (r_state != S_WRITE);
    w_req_n     = 32'd1 << i_size;
    w_size_ok   = (w_req_n <= 32'(NB));
    w_accept    = i_req && w_open && w_size_ok;
    w_reject    = i_req && w_open && !w_size_ok;
    // Move the right-aligned sized value to the top of the word so its MS
    // byte is emitted first. Only meaningful for accepted sizes.
    w_shamt     = (32'(NB) - w_req_n) << 3;
    w_aligned   = i_data << w_shamt;
    w_last_byte = (r_cnt == r_last);
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic. DONE always lasts a single cycle; a reject from DONE
  // simply falls back to IDLE like the no-request case.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_WRITE;
      end
      S_WRITE: begin
        if (w_last_byte) w_next = S_DONE;
      end
      S_DONE: begin
        if (w_accept) w_next = S_WRITE;
        else          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath and registered outputs. Byte 0 is launched on the accept edge
  // so it appears in the first cycle after the request; each following edge
  // launches the next byte until the last one, which is followed by o_done.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr      <= '0;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_last      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
      r_mem_write <= 1'b0;
    end else begin
      r_mem_write <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= w_reject;
      r_busy      <= (w_next == S_WRITE);
      if (w_accept) begin
        r_mem_write <= 1'b1;
        r_mem_addr  <= i_addr;
        r_mem_data  <= w_aligned[WORD_WIDTH-1 -: DATA_WIDTH];
        r_shift     <= w_aligned << DATA_WIDTH;
        r_addr      <= i_addr + 1'b1;
        r_cnt       <= '0;
        r_last      <= CW'(w_req_n - 32'd1);
      end else if (r_state == S_WRITE) begin
        if (!w_last_byte) begin
          r_mem_write <= 1'b1;
          r_mem_addr  <= r_addr;
          r_mem_data  <= r_shift[WORD_WIDTH-1 -: DATA_WIDTH];
          r_shift     <= r_shift << DATA_WIDTH;
          r_addr      <= r_addr + 1'b1;
          r_cnt       <= r_cnt + 1'b1;
        end else begin
          r_done      <= 1'b1;
        end
      end
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_data  = r_mem_data;
  assign o_mem_write = r_mem_write;

endmodule

// File: tb/tb_mem_store.sv
// tb_mem_store: randomized self-checking bench for mem_store.
// Expected bytes come from a plain arithmetic model of a big-endian store.
module tb_mem_store;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_req;
  logic [15:0] i_addr;
  logic [31:0] i_data;
  logic [1:0]  i_size;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic [15:0] o_mem_addr;
  logic [7:0]  o_mem_data;
  logic        o_mem_write;

  int checks = 0;
  int errors = 0;

  // Per-cycle capture; index c is cycle accept+c.
  logic        cap_we   [0:15];
  logic [15:0] cap_a    [0:15];
  logic [7:0]  cap_d    [0:15];
  logic        cap_busy [0:15];
  logic        cap_done [0:15];
  logic        cap_err  [0:15];

  mem_store #(.WORD_WIDTH(32), .ADDR_WIDTH(16), .DATA_WIDTH(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_addr(i_addr),
    .i_data(i_data), .i_size(i_size), .o_busy(o_busy), .o_done(o_done),
    .o_err(o_err), .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
    .o_mem_write(o_mem_write)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

  // Reference model: byte k of an n-byte store is the k-th most significant
  // byte of the low n bytes of the value, at address a+k mod 2**16.
  function automatic logic [7:0] exp_byte(input logic [31:0] d, input int n, input int k);
    logic [31:0] t;
    t = d >> ((n - 1 - k) * 8);
    return t[7:0];
  endfunction

  function automatic logic [15:0] exp_addr(input logic [15:0] a, input int k);
    int unsigned s;
    s = (int'(a) + k) % 65536;
    return s[15:0];
  endfunction

  task automatic start_req(input logic [15:0] a, input logic [31:0] d, input logic [1:0] s);
    i_req = 1'b1; i_addr = a; i_data = d; i_size = s;
    @(posedge i_clk); #1;
    i_req = 1'b0; i_addr = '0; i_data = '0; i_size = '0;
  endtask

  task automatic capture(input int n);
    for (int c = 1; c <= n; c++) begin
      cap_we[c] = o_mem_write; cap_a[c] = o_mem_addr; cap_d[c] = o_mem_data;
      cap_busy[c] = o_busy; cap_done[c] = o_done; cap_err[c] = o_err;
      @(posedge i_clk); #1;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge i_clk); #1; end
  endtask

  task automatic test_reset;
    i_rst = 1'b1; i_req = 1'b1; i_addr = 16'h1234; i_data = 32'hFFFF_FFFF; i_size = 2'd2;
    repeat (3) @(posedge i_clk);
    #1;
    checks++;
    if ({o_busy, o_done, o_err, o_mem_write, o_mem_addr, o_mem_data} !== 28'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b err=%b we=%b addr=%h data=%h, expected all zero",
               o_busy, o_done, o_err, o_mem_write, o_mem_addr, o_mem_data);
    end
    i_req = 1'b0; i_rst = 1'b0; i_addr = '0; i_data = '0; i_size = '0;
    idle_cycles(2);
    checks++;
    if (o_mem_write !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got we=%b busy=%b, expected 0 0", o_mem_write, o_busy);
    end
  endtask

  // Word, byte, half and wrap stores: fixed cases first, then random ones.
  task automatic test_stores(input string name, input int count, input logic [1:0] sz,
                             input logic [15:0] a0, input logic [31:0] d0);
    logic [15:0] a;
    logic [31:0] d;
    int n;
    n = 1 << sz;
    for (int t = 0; t < count; t++) begin
      a = (t == 0) ? a0 : 16'($urandom);
      d = (t == 0) ? d0 : $urandom;
      start_req(a, d, sz);
      capture(n + 2);
      for (int k = 0; k < n; k++) begin
        checks++;
        if (cap_we[1+k] !== 1'b1 || cap_a[1+k] !== exp_addr(a, k) ||
            cap_d[1+k] !== exp_byte(d, n, k) || cap_busy[1+k] !== 1'b1 || cap_done[1+k] !== 1'b0) begin
          errors++;
          $display("FAIL %s byte%0d: got we=%b addr=%h data=%h busy=%b done=%b, expected we=1 addr=%h data=%h busy=1 done=0",
                   name, k, cap_we[1+k], cap_a[1+k], cap_d[1+k], cap_busy[1+k], cap_done[1+k],
                   exp_addr(a, k), exp_byte(d, n, k));
        end
      end
      checks++;
      if (cap_done[n+1] !== 1'b1 || cap_we[n+1] !== 1'b0 || cap_busy[n+1] !== 1'b0 ||
          cap_a[n+1] !== exp_addr(a, n - 1) || cap_d[n+1] !== exp_byte(d, n, n - 1)) begin
        errors++;
        $display("FAIL %s done: got done=%b we=%b busy=%b addr=%h data=%h, expected done=1 we=0 busy=0 addr=%h data=%h",
                 name, cap_done[n+1], cap_we[n+1], cap_busy[n+1], cap_a[n+1], cap_d[n+1],
                 exp_addr(a, n - 1), exp_byte(d, n, n - 1));
      end
      checks++;
      if (cap_done[n+2] !== 1'b0 || cap_we[n+2] !== 1'b0 || cap_err[n+2] !== 1'b0) begin
        errors++;
        $display("FAIL %s after_done: got done=%b we=%b err=%b, expected 0 0 0",
                 name, cap_done[n+2], cap_we[n+2], cap_err[n+2]);
      end
    end
  endtask

  task automatic test_busy;
    logic [31:0] d;
    d = 32'h0102_0304;
    start_req(16'h0300, d, 2'd2);
    for (int c = 1; c <= 8; c++) begin
      i_req = (c == 2 || c == 3); i_addr = 16'h0400; i_data = 32'hCAFE_BABE; i_size = 2'd2;
      cap_we[c] = o_mem_write; cap_a[c] = o_mem_addr; cap_d[c] = o_mem_data; cap_done[c] = o_done;
      @(posedge i_clk); #1;
    end
    i_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (cap_we[1+k] !== 1'b1 || cap_a[1+k] !== exp_addr(16'h0300, k) || cap_d[1+k] !== exp_byte(d, 4, k)) begin
        errors++;
        $display("FAIL busy_first byte%0d: got we=%b addr=%h data=%h, expected we=1 addr=%h data=%h",
                 k, cap_we[1+k], cap_a[1+k], cap_d[1+k], exp_addr(16'h0300, k), exp_byte(d, 4, k));
      end
    end
    for (int c = 5; c <= 8; c++) begin
      checks++;
      if (cap_we[c] !== 1'b0) begin
        errors++;
        $display("FAIL busy_ignored cycle%0d: got we=%b addr=%h, expected we=0", c, cap_we[c], cap_a[c]);
      end
    end
    checks++;
    if (cap_done[5] !== 1'b1) begin
      errors++;
      $display("FAIL busy_done: got %b, expected 1", cap_done[5]);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] da, db;
    da = $urandom; db = $urandom;
    start_req(16'h0500, da, 2'd1);
    idle_cycles(2);
    checks++;
    if (o_done !== 1'b1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done: got done=%b busy=%b, expected 1 0", o_done, o_busy);
    end
    start_req(16'h0600, db, 2'd2);
    capture(5);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (cap_we[1+k] !== 1'b1 || cap_a[1+k] !== exp_addr(16'h0600, k) || cap_d[1+k] !== exp_byte(db, 4, k)) begin
        errors++;
        $display("FAIL b2b_second byte%0d: got we=%b addr=%h data=%h, expected we=1 addr=%h data=%h",
                 k, cap_we[1+k], cap_a[1+k], cap_d[1+k], exp_addr(16'h0600, k), exp_byte(db, 4, k));
      end
    end
    checks++;
    if (cap_done[5] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_done: got %b, expected 1", cap_done[5]);
    end
    idle_cycles(1);
  endtask

  task automatic test_reject;
    start_req(16'h0700, $urandom, 2'd3);
    capture(3);
    checks++;
    if (cap_err[1] !== 1'b1 || cap_we[1] !== 1'b0 || cap_busy[1] !== 1'b0) begin
      errors++;
      $display("FAIL reject_idle: got err=%b we=%b busy=%b, expected 1 0 0", cap_err[1], cap_we[1], cap_busy[1]);
    end
    checks++;
    if (cap_err[2] !== 1'b0 || cap_we[2] !== 1'b0 || cap_busy[2] !== 1'b0 || cap_done[2] !== 1'b0) begin
      errors++;
      $display("FAIL reject_after: got err=%b we=%b busy=%b done=%b, expected 0 0 0 0",
               cap_err[2], cap_we[2], cap_busy[2], cap_done[2]);
    end
    // Reject issued on the DONE cycle of a byte store.
    start_req(16'h0710, 32'h0000_00AB, 2'd0);
    checks++;
    if (o_mem_write !== 1'b1 || o_mem_data !== 8'hAB) begin
      errors++;
      $display("FAIL reject_pre_byte: got we=%b data=%h, expected 1 ab", o_mem_write, o_mem_data);
    end
    idle_cycles(1);
    checks++;
    if (o_done !== 1'b1) begin
      errors++;
      $display("FAIL reject_pre_done: got %b, expected 1", o_done);
    end
    start_req(16'h0720, $urandom, 2'd3);
    capture(2);
    checks++;
    if (cap_err[1] !== 1'b1 || cap_we[1] !== 1'b0 || cap_busy[1] !== 1'b0 || cap_done[1] !== 1'b0) begin
      errors++;
      $display("FAIL reject_done: got err=%b we=%b busy=%b done=%b, expected 1 0 0 0",
               cap_err[1], cap_we[1], cap_busy[1], cap_done[1]);
    end
    checks++;
    if (cap_err[2] !== 1'b0 || cap_we[2] !== 1'b0) begin
      errors++;
      $display("FAIL reject_done_after: got err=%b we=%b, expected 0 0", cap_err[2], cap_we[2]);
    end
  endtask

  task automatic test_reset_mid;
    start_req(16'h0800, 32'h5566_7788, 2'd2);
    idle_cycles(1);
    checks++;
    if (o_mem_write !== 1'b1 || o_mem_data !== 8'h66) begin
      errors++;
      $display("FAIL rstmid_byte1: got we=%b data=%h, expected 1 66", o_mem_write, o_mem_data);
    end
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    checks++;
    if (o_mem_write !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_stop: got we=%b busy=%b done=%b, expected 0 0 0", o_mem_write, o_busy, o_done);
    end
    capture(5);
    for (int c = 1; c <= 5; c++) begin
      checks++;
      if (cap_we[c] !== 1'b0 || cap_done[c] !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_quiet cycle%0d: got we=%b done=%b, expected 0 0", c, cap_we[c], cap_done[c]);
      end
    end
  endtask

  task automatic test_random_mix;
    logic [1:0] sz;
    for (int t = 0; t < 30; t++) begin
      sz = 2'($urandom_range(0, 3));
      if (sz == 2'd3) begin
        start_req(16'($urandom), $urandom, sz);
        checks++;
        if (o_err !== 1'b1 || o_mem_write !== 1'b0) begin
          errors++;
          $display("FAIL random_reject t%0d: got err=%b we=%b, expected 1 0", t, o_err, o_mem_write);
        end
        idle_cycles(1);
      end else begin
        test_stores("random", 1, sz, 16'($urandom), $urandom);
      end
      idle_cycles($urandom_range(0, 2));
    end
  endtask

  initial begin
    i_rst = 1'b1; i_req = 1'b0; i_addr = '0; i_data = '0; i_size = '0;
    #1;
    test_reset;
    test_stores("word", 4, 2'd2, 16'h0100, 32'hDEAD_BEEF);
    test_stores("byte", 3, 2'd0, 16'h0010, 32'h1234_5678);
    test_stores("half", 3, 2'd1, 16'h0200, 32'h1234_5678);
    test_stores("wrap", 1, 2'd2, 16'hFFFE, 32'h1122_3344);
    test_stores("wrap_half", 1, 2'd1, 16'hFFFF, 32'h0000_A55A);
    test_busy;
    test_back_to_back;
    test_reject;
    test_reset_mid;
    test_stores("after_reset", 1, 2'd2, 16'h0100, 32'hDEAD_BEEF);
    test_random_mix;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
